soundrive_dac: RTL and testbench

Parametrised successor to the single-port SpecDrum latch. Captures Z80 OUT writes into CHANNELS 8-bit DAC registers and supports two addressing modes: SpecDrum compatibility (one port loads all channels) and Soundrive/Covox (one port per channel). A registered two-stage mixer sums the channels into left/right outputs. The block sits on the I/O bus beside the ULA and feeds the audio mixer.

---
 rtl/soundrive_dac.sv | 158 +++++++++++++++
 tb/tb_soundrive_dac.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/soundrive_dac.sv
// Purpose : Z80 I/O-mapped multi-channel 8-bit DAC latch (SpecDrum / Soundrive / Covox) with a two-stage L/R mixer.
// Latency : a channel write appears on left/right 2 ce ticks after the strobe edge; valid pulses on every ce.
// Backpr. : none -- the bus write is always accepted and the mixer output is free-running on ce.
//
// Ports:
//   reset       async active-low reset
//   clock       system clock
//   ce          clock enable; all state except reset advances only when ce=1
//   iorq, wr    Z80 IORQ_n / WR_n, active-low
//   a, d        I/O address low byte and data bus
//   mode        0 = SpecDrum (SD_PORT loads every channel), 1 = Soundrive (one port per channel)
//   left/right  registered mix of the lower / upper half of the channels
//   valid       one-clock pulse whenever left/right are updated
//
// Optional build macro: SOUNDRIVE_SIGNED_EN
//   Channels are treated as offset-binary and converted to two's complement before mixing,
//   so that the midscale reset value mixes to 0 and left/right become signed.

module soundrive_dac #(
    parameter int          DW        = 8,
    parameter int          CHANNELS  = 4,
    parameter logic [7:0]  PORT_BASE = 8'h0F,
    parameter logic [7:0]  SD_PORT   = 8'hDF,
    parameter int          OW        = DW + $clog2(CHANNELS / 2) + 1
) (
    input  logic                  reset,
    input  logic                  clock,
    input  logic                  ce,
    input  logic                  iorq,
    input  logic                  wr,
    input  logic [7:0]            a,
    input  logic [DW-1:0]         d,
    input  logic                  mode,
`ifdef SOUNDRIVE_SIGNED_EN
    output logic signed [OW-1:0]  left,
    output logic signed [OW-1:0]  right,
`else
    output logic [OW-1:0]         left,
    output logic [OW-1:0]         right,
`endif
    output logic                  valid
);

    localparam int            HALF = CHANNELS / 2;
    localparam logic [DW-1:0] MID  = {1'b1, {(DW-1){1'b0}}};

    generate
        if (CHANNELS != 2 && CHANNELS != 4) begin : g_bad_channels
            $error("soundrive_dac: CHANNELS must be 2 or 4");
        end
    endgenerate

    // Soundrive port of channel i: bit 0 of the index sets A4, bit 1 sets A6.
    function automatic logic [7:0] chan_port(input int idx);
        logic [7:0] p;
        p = PORT_BASE;
        if (idx[0]) p = p | 8'h10;
        if (idx[1]) p = p | 8'h40;
        return p;
    endfunction

    // Widen a channel to the mixer width, unsigned or offset-binary -> two's complement.
    function automatic logic [OW-1:0] widen(input logic [DW-1:0] ch);
`ifdef SOUNDRIVE_SIGNED_EN
        return {{(OW-DW){~ch[DW-1]}}, ~ch[DW-1], ch[DW-2:0]};
`else
        return {{(OW-DW){1'b0}}, ch};
`endif
    endfunction

    // ------------------------------------------------------------------
    // Write strobe: first ce tick of an IORQ_n & WR_n low cycle only.
    // ------------------------------------------------------------------
    logic wcyc;
    logic wprev;
    logic strobe;

    assign wcyc   = !iorq && !wr;
    assign strobe = ce && wcyc && !wprev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wprev <= 1'b0;
        end else if (ce) begin
            wprev <= wcyc;
        end
    end

    // ------------------------------------------------------------------
    // Address decode; mode is taken as it stands on the strobe clock.
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] ld;

    always_comb begin
        ld = '0;
        if (strobe) begin
            if (!mode) begin
                if (a == SD_PORT) ld = '1;
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (a == chan_port(i)) ld[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel registers (strobe already includes ce).
    // ------------------------------------------------------------------
    logic [DW-1:0] chan [CHANNELS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) chan[i] <= MID;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ld[i]) chan[i] <= d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mixer: stage 1 registers the half sums, stage 2 presents them.
    // OW is sized so that the sum of HALF full-scale channels cannot wrap.
    // ------------------------------------------------------------------
    logic [OW-1:0] sum_l;
    logic [OW-1:0] sum_r;
    logic [OW-1:0] sl;
    logic [OW-1:0] sr;

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i < HALF) sum_l = sum_l + widen(chan[i]);
            else          sum_r = sum_r + widen(chan[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sl    <= '0;
            sr    <= '0;
            left  <= '0;
            right <= '0;
            valid <= 1'b0;
        end else begin
            valid <= ce;
            if (ce) begin
                sl    <= sum_l;
                sr    <= sum_r;
                left  <= sl;
                right <= sr;
            end
        end
    end

endmodule

// File: tb/tb_soundrive_dac.sv
// Directed bench for soundrive_dac with the default parameters (CHANNELS=4, OW=10).
// Each step drives inputs 1 ns after a rising edge and samples there as well.
// Expected mixes come from mix(), which follows the build's summation mode.

module tb_soundrive_dac;

    localparam int DW = 8;
    localparam int OW = 10;

    logic          reset;
    logic          clock;
    logic          ce;
    logic          iorq;
    logic          wr;
    logic [7:0]    a;
    logic [DW-1:0] d;
    logic          mode;
    logic [OW-1:0] left;
    logic [OW-1:0] right;
    logic          valid;

    int n_checks = 0;
    int n_fails  = 0;

    soundrive_dac dut (
        .reset (reset),
        .clock (clock),
        .ce    (ce),
        .iorq  (iorq),
        .wr    (wr),
        .a     (a),
        .d     (d),
        .mode  (mode),
        .left  (left),
        .right (right),
        .valid (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Mix of two channel values in this build's arithmetic.
    function automatic logic [OW-1:0] mix(input logic [7:0] x, input logic [7:0] y);
`ifdef SOUNDRIVE_SIGNED_EN
        return {{(OW-8){~x[7]}}, ~x[7], x[6:0]} + {{(OW-8){~y[7]}}, ~y[7], y[6:0]};
`else
        return {{(OW-8){1'b0}}, x} + {{(OW-8){1'b0}}, y};
`endif
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] observed, input logic [OW-1:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step(input logic c);
        ce = c;
        @(posedge clock);
        #1;
    endtask

    // One write cycle: strobe tick, bus release tick, then two ticks so the mix reaches the outputs.
    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        a = addr; d = data; iorq = 1'b0; wr = 1'b0;
        step(1'b1);
        iorq = 1'b1; wr = 1'b1;
        step(1'b1);
        step(1'b1);
        step(1'b1);
    endtask

    initial begin
        reset = 1'b0; ce = 1'b0; iorq = 1'b1; wr = 1'b1; a = 8'h00; d = 8'h00; mode = 1'b0;
        step(1'b0);
        step(1'b1);
        check("reset_left",  left,  10'h000);
        check("reset_right", right, 10'h000);
        check("reset_valid", {9'd0, valid}, 10'd1 - 10'd1);

        // Release reset; pipeline fills after two ce ticks.
        reset = 1'b1;
        step(1'b1);
        check("fill1_valid", {9'd0, valid}, 10'd1);
        check("fill1_left",  left, 10'h000);
        step(1'b1);
        step(1'b1);
        check("fill3_left",  left,  mix(8'h80, 8'h80));   // 0x100 unsigned
        check("fill3_right", right, mix(8'h80, 8'h80));
        step(1'b0);
        check("noce_valid",  {9'd0, valid}, 10'd0);
        check("noce_hold",   left,  mix(8'h80, 8'h80));

        // SpecDrum mode: DF loads every channel, Soundrive port ignored.
        mode = 1'b0;
        io_write(8'hDF, 8'h40);
        check("sd_left",  left,  mix(8'h40, 8'h40));      // 0x080
        check("sd_right", right, mix(8'h40, 8'h40));
        io_write(8'h0F, 8'h99);
        check("sd_ign0F", left,  mix(8'h40, 8'h40));

        // Soundrive mode, latency check on the first write (ch0 <= FF).
        mode = 1'b1;
        a = 8'h0F; d = 8'hFF; iorq = 1'b0; wr = 1'b0;
        step(1'b1);
        check("lat_edge0", left, mix(8'h40, 8'h40));
        iorq = 1'b1; wr = 1'b1;
        step(1'b1);
        check("lat_edge1", left, mix(8'h40, 8'h40));
        step(1'b1);
        check("lat_edge2", left, mix(8'hFF, 8'h40));      // 0x13F
        io_write(8'h1F, 8'h01);
        io_write(8'h4F, 8'h10);
        io_write(8'h5F, 8'h20);
        check("srd_left",  left,  mix(8'hFF, 8'h01));     // 0x100
        check("srd_right", right, mix(8'h10, 8'h20));     // 0x030
        io_write(8'hDF, 8'h00);
        check("srd_ignDF_l", left,  mix(8'hFF, 8'h01));
        check("srd_ignDF_r", right, mix(8'h10, 8'h20));

        // Cycle held over 5 ce ticks (with a ce gap); data changes after the strobe.
        a = 8'h0F; d = 8'h11; iorq = 1'b0; wr = 1'b0;
        step(1'b1);
        d = 8'h22;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        iorq = 1'b1; wr = 1'b1;
        step(1'b1);
        step(1'b1);
        check("held_left",  left,  mix(8'h11, 8'h01));    // 0x012
        check("held_right", right, mix(8'h10, 8'h20));

        // Mode flips to 1 while a DF cycle waits for ce: decode uses mode at the strobe.
        mode = 1'b0;
        a = 8'hDF; d = 8'h77; iorq = 1'b0; wr = 1'b0;
        step(1'b0);
        mode = 1'b1;
        step(1'b1);
        iorq = 1'b1; wr = 1'b1;
        step(1'b1);
        step(1'b1);
        check("modeflip_left", left, mix(8'h11, 8'h01));

        // Reset between strobe and stage 2.
        a = 8'h1F; d = 8'h81; iorq = 1'b0; wr = 1'b0;
        step(1'b1);
        iorq = 1'b1; wr = 1'b1;
        step(1'b1);
        reset = 1'b0;
        #1;
        check("rstmid_left",  left,  10'h000);
        check("rstmid_right", right, 10'h000);
        check("rstmid_valid", {9'd0, valid}, 10'd0);
        step(1'b1);
        reset = 1'b1;
        step(1'b0);
        check("rel_novalid", {9'd0, valid}, 10'd0);
        step(1'b1);
        check("rel_nostale", left, 10'h000);
        step(1'b1);
        check("rel_mid_l", left,  mix(8'h80, 8'h80));
        check("rel_mid_r", right, mix(8'h80, 8'h80));

        // Write cycle held through reset release strobes on the first ce.
        reset = 1'b0;
        mode = 1'b1; a = 8'h0F; d = 8'h55; iorq = 1'b0; wr = 1'b0;
        step(1'b1);
        reset = 1'b1;
        step(1'b1);
        iorq = 1'b1; wr = 1'b1;
        step(1'b1);
        step(1'b1);
        check("relwr_left",  left,  mix(8'h55, 8'h80));   // 0x0D5
        check("relwr_right", right, mix(8'h80, 8'h80));

`ifdef SOUNDRIVE_SIGNED_EN
        io_write(8'h0F, 8'h00);
        check("signed_neg", left, 10'h380);               // -128 sign-extended
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
